// File: rtl/ifetch_ctrl_if.sv
// Loader handshake and instruction-memory port shared by the fetch controller.
// The master side is the loader plus memory; the slave side is the controller.
interface ifetch_ctrl_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [31:0] IAddr;
    logic        InsMemRW;
    logic [7:0]  mem_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, IAddr, InsMemRW, mem_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, IAddr, InsMemRW, mem_wdata
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, streams loader words into the
// byte-wide big-endian instruction memory, and detects halt / bad PC.
module ifetch_ctrl #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [5:0]  HALT_OP   = 6'b111111
) (
    input  logic         CLK,
    input  logic         Reset,
    ifetch_ctrl_if.slave bus,
    input  logic         start,
    input  logic         PCWre,
    input  logic [1:0]   PCSrc,
    input  logic [5:0]   op,
    input  logic [15:0]  immediate,
    input  logic [25:0]  jaddr,
    output logic         running,
    output logic         halted,
    output logic         err
);

    // wptr must be able to hold MEM_BYTES itself to flag a full memory
    localparam int unsigned WW     = $clog2(MEM_BYTES + 1);
    localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {StIdle, StLoad, StReady, StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [WW-1:0]   wptr_q, wptr_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic            busy_q, busy_d;   // latched word still being written
    logic [31:0]     word_q, word_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    logic [31:0]     p4, next_pc;
    logic            pc_bad, wptr_full, load_state, ld_ready;
    logic [7:0]      cur_byte;

    // Next-PC selection and range check
    always_comb begin
        p4 = pc_q + 32'd4;
        case (PCSrc)
            2'b01:   next_pc = p4 + {{14{immediate[15]}}, immediate, 2'b00};
            2'b10:   next_pc = {p4[31:28], jaddr, 2'b00};
            default: next_pc = p4;
        endcase
        pc_bad = (next_pc > PC_MAX) || (next_pc[1:0] != 2'b00);
    end

    // Loader handshake and memory port drive
    always_comb begin
        load_state = (state_q == StIdle) || (state_q == StLoad);
        wptr_full  = (wptr_q == WW'(MEM_BYTES));
        ld_ready   = load_state && !busy_q && !wptr_full;
        case (bcnt_q)
            2'd0:    cur_byte = word_q[31:24];
            2'd1:    cur_byte = word_q[23:16];
            2'd2:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
        endcase
        bus.ld_ready  = ld_ready;
        bus.InsMemRW  = busy_q;
        bus.mem_wdata = busy_q ? cur_byte : 8'h00;
        if (busy_q) begin
            bus.IAddr = 32'(wptr_q) + {30'b0, bcnt_q};
        end else if (state_q == StLoad) begin
            bus.IAddr = 32'(wptr_q);
        end else begin
            bus.IAddr = pc_q;
        end
        running = (state_q == StRun);
        halted  = (state_q == StHalt);
        err     = err_q;
    end

    // Next-state logic for the sequencer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        bcnt_d  = bcnt_q;
        busy_d  = busy_q;
        word_d  = word_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StLoad: begin
                if (busy_q) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        busy_d = 1'b0;
                        bcnt_d = 2'd0;
                        wptr_d = wptr_q + WW'(4);
                        if (last_q) state_d = StReady;
                    end
                end else if (bus.ld_valid && ld_ready) begin
                    word_d  = bus.ld_data;
                    last_d  = bus.ld_last;
                    busy_d  = 1'b1;
                    bcnt_d  = 2'd0;
                    state_d = StLoad;
                end else if (bus.ld_valid && wptr_full) begin
                    err_d = 1'b1;
                end else if (state_q == StIdle && start) begin
                    // memory assumed preloaded externally
                    state_d = StRun;
                    pc_d    = RESET_PC;
                end
            end
            StReady: begin
                if (start) begin
                    state_d = StRun;
                    pc_d    = RESET_PC;
                end
            end
            StRun: begin
                // a bad target only matters when the PC would actually move
                if (PCWre && pc_bad) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else if (op == HALT_OP) begin
                    state_d = StHalt;
                end else if (PCWre) begin
                    pc_d = next_pc;
                end
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            wptr_q  <= '0;
            bcnt_q  <= 2'd0;
            busy_q  <= 1'b0;
            word_q  <= 32'h0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            bcnt_q  <= bcnt_d;
            busy_q  <= busy_d;
            word_q  <= word_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a behavioural model predicts memory writes
// and fetch addresses; a negedge monitor compares whatever the DUT presents.
module tb_ifetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start, PCWre;
    logic [1:0]  PCSrc;
    logic [5:0]  op;
    logic [15:0] immediate;
    logic [25:0] jaddr;
    logic        running, halted, err;

    ifetch_ctrl_if bus();

    ifetch_ctrl dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .start     (start),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .op        (op),
        .immediate (immediate),
        .jaddr     (jaddr),
        .running   (running),
        .halted    (halted),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [31:0] exp_pc_q[$];
    logic [7:0]  mem   [64];   // bytes the DUT actually wrote
    logic [7:0]  m_mem [64];   // bytes the model expects
    int          wr_count;

    // Reference model state
    int unsigned m_wptr;
    logic [31:0] m_pc;
    bit          m_run, m_halt, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every write byte and every running cycle
    always @(negedge CLK) begin
        logic [31:0] a;
        logic [7:0]  d;
        if (!Reset) begin
            if (bus.InsMemRW) begin
                wr_count++;
                if (bus.IAddr < 32'd64) mem[bus.IAddr[5:0]] = bus.mem_wdata;
                if (exp_addr_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected write: actual addr=0x%08h required=no write",
                             bus.IAddr);
                end else begin
                    a = exp_addr_q.pop_front();
                    d = exp_data_q.pop_front();
                    chk("write addr", bus.IAddr, a);
                    chk("write data", 32'(bus.mem_wdata), 32'(d));
                end
            end
            if (running) begin
                if (exp_pc_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected fetch: actual IAddr=0x%08h required=not running",
                             bus.IAddr);
                end else begin
                    a = exp_pc_q.pop_front();
                    chk("fetch IAddr", bus.IAddr, a);
                end
            end
        end
    end

    task automatic assert_reset();
        Reset = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_data = 32'h0;
        bus.ld_last = 1'b0;
        start = 1'b0;
        PCWre = 1'b0;
        PCSrc = 2'b00;
        op = 6'h0;
        immediate = 16'h0;
        jaddr = 26'h0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_pc_q.delete();
        wr_count = 0;
        m_wptr = 0;
        m_pc = 32'h0;
        m_run = 0;
        m_halt = 0;
        m_err = 0;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #2 Reset = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    task automatic load_word(input logic [31:0] data, input bit last);
        bit accepted = 0;
        bus.ld_valid = 1'b1;
        bus.ld_data = data;
        bus.ld_last = last;
        if (m_wptr < 64) begin
            for (int i = 0; i < 20 && !accepted; i++) begin
                @(negedge CLK);
                if (bus.ld_ready) accepted = 1;
                @(posedge CLK);
                #1;
            end
            if (!accepted) begin
                n_chk++;
                n_fail++;
                $display("FAIL ld_ready timeout: actual=0 required=1 within 20 cycles");
            end else begin
                for (int k = 0; k < 4; k++) begin
                    exp_addr_q.push_back(32'(m_wptr + k));
                    exp_data_q.push_back(8'((data >> (24 - 8 * k)) & 32'hFF));
                    m_mem[m_wptr + k] = 8'((data >> (24 - 8 * k)) & 32'hFF);
                end
                m_wptr += 4;
            end
        end else begin
            // memory full: word must be refused and the overflow flagged
            for (int i = 0; i < 8; i++) begin
                @(negedge CLK);
                if (i < 3) chk("ld_ready when full", 32'(bus.ld_ready), 32'd0);
            end
            @(posedge CLK);
            #1;
            m_err = 1;
            chk("overflow err", 32'(err), 32'(m_err));
        end
        bus.ld_valid = 1'b0;
        bus.ld_last = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        m_run = 1;
        m_pc = 32'h0;
    endtask

    // One RUN cycle: expected fetch address pushed, model advanced after the edge
    task automatic step(input logic [5:0] o, input logic [1:0] src, input bit we,
                        input logic [15:0] imm, input logic [25:0] ja);
        logic [31:0] nxt;
        int          off;
        op = o;
        PCSrc = src;
        PCWre = we;
        immediate = imm;
        jaddr = ja;
        if (m_run) exp_pc_q.push_back(m_pc);
        @(posedge CLK);
        #1;
        if (m_run) begin
            off = int'($signed(imm));
            case (src)
                2'b01:   nxt = m_pc + 32'd4 + 32'(off * 4);
                2'b10:   nxt = ((m_pc + 32'd4) & 32'hF000_0000) + 32'(ja) * 32'd4;
                default: nxt = m_pc + 32'd4;
            endcase
            if (we && (nxt > 32'd60 || nxt % 4 != 0)) begin
                m_err = 1;
                m_run = 0;
                m_halt = 1;
            end else if (o == 6'h3F) begin
                m_run = 0;
                m_halt = 1;
            end else if (we) begin
                m_pc = nxt;
            end
        end
    endtask

    task automatic rand_step();
        logic [5:0] o;
        o = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
        step(o, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
             16'($urandom_range(0, 31)) - 16'd16, 26'($urandom_range(0, 18)));
    endtask

    task automatic check_status(input string tag);
        chk({tag, " running"}, 32'(running), 32'(m_run));
        chk({tag, " halted"}, 32'(halted), 32'(m_halt));
        chk({tag, " err"}, 32'(err), 32'(m_err));
        if (m_halt) chk({tag, " halt IAddr"}, bus.IAddr, m_pc);
        chk({tag, " fetch queue drained"}, 32'(exp_pc_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        assert_reset();
        #1;
        // Reset state
        chk("reset ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("reset InsMemRW", 32'(bus.InsMemRW), 32'd0);
        chk("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset IAddr", bus.IAddr, 32'h0);
        chk("reset running", 32'(running), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        release_reset();

        // Reset mid-word after two bytes
        load_word(32'hA5A5_1234, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        chk("mid-word writing", 32'(bus.InsMemRW), 32'd1);
        assert_reset();
        #1;
        chk("mid-word reset InsMemRW", 32'(bus.InsMemRW), 32'd0);
        chk("mid-word reset ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("mid-word reset IAddr", bus.IAddr, 32'h0);
        release_reset();

        // Two-word program, then run to halt
        load_word(32'h8C01_0004, 1'b0);
        @(negedge CLK);
        chk("ld_ready low in byte cycle", 32'(bus.ld_ready), 32'd0);
        @(posedge CLK);
        #1;
        load_word(32'hFC00_0000, 1'b1);
        repeat (4) @(posedge CLK);
        #1;
        chk("ready: ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("ready: InsMemRW", 32'(bus.InsMemRW), 32'd0);
        chk("write byte count", 32'(wr_count), 32'd8);
        for (int i = 0; i < 8; i++) chk("program byte", 32'(mem[i]), 32'(m_mem[i]));
        chk("mem[0]", 32'(mem[0]), 32'h8C);
        chk("mem[4]", 32'(mem[4]), 32'hFC);
        do_start();
        step(6'h23, 2'b00, 1'b1, 16'h0, 26'h0);
        step(6'h3F, 2'b00, 1'b1, 16'h0, 26'h0);
        chk("halt IAddr", bus.IAddr, 32'h4);
        step(6'h00, 2'b00, 1'b1, 16'h0, 26'h0);
        check_status("halt");

        // Branch, jump and stall
        do_reset();
        do_start();
        step(6'h0, 2'b00, 1'b1, 16'h0, 26'h0);
        step(6'h0, 2'b00, 1'b1, 16'h0, 26'h0);
        chk("pc 8", bus.IAddr, 32'h8);
        step(6'h4, 2'b01, 1'b1, 16'hFFFE, 26'h0);
        chk("branch back", bus.IAddr, 32'h4);
        step(6'h2, 2'b10, 1'b1, 16'h0, 26'h3);
        chk("jump", bus.IAddr, 32'hC);
        step(6'h0, 2'b00, 1'b0, 16'h0, 26'h0);
        chk("stall", bus.IAddr, 32'hC);
        step(6'h0, 2'b11, 1'b1, 16'h0, 26'h0);
        check_status("branch/jump");

        // Fill memory and overflow
        do_reset();
        for (int i = 0; i < 16; i++) load_word($urandom, 1'b0);
        chk("no err before overflow", 32'(err), 32'd0);
        load_word(32'hDEAD_BEEF, 1'b0);
        chk("full write count", 32'(wr_count), 32'd64);
        for (int i = 60; i < 64; i++) chk("last word byte", 32'(mem[i]), 32'(m_mem[i]));
        chk("write queue drained", 32'(exp_addr_q.size()), 32'd0);

        // Run off the end of memory
        do_reset();
        do_start();
        repeat (16) step(6'h0, 2'b00, 1'b1, 16'h0, 26'h0);
        chk("oob err", 32'(err), 32'd1);
        chk("oob halted", 32'(halted), 32'd1);
        chk("oob IAddr", bus.IAddr, 32'd60);
        check_status("oob");

        // Random loads followed by a short random run from READY
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) load_word($urandom, (i == n - 1));
            repeat (4) @(posedge CLK);
            #1;
            chk("rand load ready", 32'(bus.ld_ready), 32'd0);
            chk("rand write queue drained", 32'(exp_addr_q.size()), 32'd0);
            for (int i = 0; i < 4 * n; i++) chk("rand byte", 32'(mem[i]), 32'(m_mem[i]));
            do_start();
            for (int i = 0; i < 10 && m_run; i++) rand_step();
            check_status("rand load run");
        end

        // Random fetch sequences from IDLE
        for (int t = 0; t < 20; t++) begin
            do_reset();
            do_start();
            for (int i = 0; i < 40 && m_run; i++) rand_step();
            check_status("rand run");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
